// File: rtl/miriscv_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_irq_ctrl
// Brief    : Serves one masked external interrupt at a time to the core and
//            returns a one-hot completion pulse on mret. Round-robin scan by
//            default; define MIRISCV_IRQ_FIXED_PRIO_EN for strict priority
//            (line 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_irq_ctrl #(
    parameter int N_IRQ = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    localparam logic [0:0]       c_st_idle   = 1'b0;
    localparam logic [0:0]       c_st_active = 1'b1;
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(N_IRQ - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_int, w_int_nxt;
    logic [N_IRQ-1:0] r_fin, w_fin_nxt;
    logic             w_hit;
    logic [IDX_W-1:0] w_sel;

    function automatic logic [IDX_W-1:0] f_wrap_inc(input logic [IDX_W-1:0] v);
        return (v == c_last_idx) ? '0 : v + 1'b1;
    endfunction

`ifdef MIRISCV_IRQ_FIXED_PRIO_EN
    logic [N_IRQ-1:0] w_pend;

    assign w_pend = int_req_i & mie_i;

    // Descending walk so the lowest pending index is the last one written.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_hit = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

    assign w_hit = int_req_i[r_cnt] & mie_i[r_cnt];
    assign w_sel = r_cnt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_int_nxt   = 1'b0;
        w_fin_nxt   = '0;
`ifndef MIRISCV_IRQ_FIXED_PRIO_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            c_st_idle: begin
                if (w_hit) begin
                    w_idx_nxt   = w_sel;
                    w_state_nxt = c_st_active;
                    w_int_nxt   = 1'b1;
                end
`ifndef MIRISCV_IRQ_FIXED_PRIO_EN
                else begin
                    w_cnt_nxt = f_wrap_inc(r_cnt);
                end
`endif
            end
            c_st_active: begin
                // Service is latched on r_idx; requests and mask are ignored here.
                if (int_rst_i) begin
                    w_fin_nxt[r_idx] = 1'b1;
                    w_state_nxt      = c_st_idle;
`ifndef MIRISCV_IRQ_FIXED_PRIO_EN
                    w_cnt_nxt        = f_wrap_inc(r_idx);
`endif
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
            r_int   <= 1'b0;
            r_fin   <= '0;
`ifndef MIRISCV_IRQ_FIXED_PRIO_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_int   <= w_int_nxt;
            r_fin   <= w_fin_nxt;
`ifndef MIRISCV_IRQ_FIXED_PRIO_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign int_o     = r_int;
    assign int_fin_o = r_fin;
    assign mcause_o  = (r_state == c_st_active) ?
                       {1'b1, {(31 - IDX_W){1'b0}}, r_idx} : 32'h0;

endmodule
`default_nettype wire
